// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared widths, instruction field positions, opcodes and FSM encoding
// for the ALU instruction sequencer.
package alu_seq_pkg;
    localparam int DW = 4;
    localparam int AW = 2;
    localparam int IW = 9;
    localparam int OP_LSB = 6;
    localparam int RD_LSB = 4;
    localparam int RS_LSB = 2;
    localparam int RT_LSB = 0;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ASR = 3'b101;
    localparam logic [2:0] OP_EQ  = 3'b110;
    localparam logic [2:0] OP_GT  = 3'b111;
    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;
endpackage

// File: rtl/alu_instr_sequencer_if.sv
// alu_instr_sequencer_if: host-side bus of the sequencer.
//   instruction port: instr_valid/instr_ready/instr
//   host load port:   ld_en/ld_addr/ld_data
//   result port:      res_valid/res_data/res_addr
// master = host, slave = sequencer.
interface alu_instr_sequencer_if;
    import alu_seq_pkg::*;
    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] instr;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic [AW-1:0] res_addr;
    modport master (
        output instr_valid, instr, ld_en, ld_addr, ld_data,
        input  instr_ready, res_valid, res_data, res_addr
    );
    modport slave (
        input  instr_valid, instr, ld_en, ld_addr, ld_data,
        output instr_ready, res_valid, res_data, res_addr
    );
endinterface

// File: rtl/Decode_And_Execute.sv
// Decode_And_Execute: 4-bit combinational ALU.
//   rs, rt : operands
//   sel    : operation select
//   rd     : result (mod 16)
module Decode_And_Execute
    import alu_seq_pkg::*;
(
    input  logic [DW-1:0] rs,
    input  logic [DW-1:0] rt,
    input  logic [2:0]    sel,
    output logic [DW-1:0] rd
);
    always_comb begin
        rd = '0;
        case (sel)
            OP_ADD: rd = rs + rt;
            OP_SUB: rd = rs - rt;
            OP_AND: rd = rs & rt;
            OP_OR:  rd = rs | rt;
            OP_ROL: rd = {rs[2:0], rs[3]};
            OP_ASR: rd = {rt[3], rt[3:1]};
            OP_EQ:  rd = {3'b111, rs == rt};
            default: rd = {3'b101, rs > rt};
        endcase
    end
endmodule

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: 4x4 register file, async reset to RESET_VAL.
//   clk, rst_n               : clock, async active-low reset
//   i_we/i_waddr/i_wdata     : single synchronous write port
//   i_rs_addr -> o_rs_data   : combinational read
//   i_rt_addr -> o_rt_data   : combinational read
//   i_dbg_addr -> o_dbg_data : combinational debug read
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter logic [DW-1:0] RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_rs_addr,
    output logic [DW-1:0] o_rs_data,
    input  logic [AW-1:0] i_rt_addr,
    output logic [DW-1:0] o_rt_data,
    input  logic [AW-1:0] i_dbg_addr,
    output logic [DW-1:0] o_dbg_data
);
    logic [DW-1:0] r_mem [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_mem <= '{default: RESET_VAL};
        else if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rs_data  = r_mem[i_rs_addr];
    assign o_rt_data  = r_mem[i_rt_addr];
    assign o_dbg_data = r_mem[i_dbg_addr];
endmodule

// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer: runs instructions through Decode_And_Execute over a 4-entry
// register file with an IDLE -> READ -> EXEC -> WB FSM.
//   clk, rst_n      : clock, async active-low reset
//   bus (slave)     : instruction, host load and result ports
//   busy            : FSM not in IDLE
//   dbg_addr/data   : combinational register-file read
//   instr_count     : retired-instruction count when INSTR_COUNT_EN is defined, else 0
module alu_instr_sequencer
    import alu_seq_pkg::*;
#(
    parameter int            ALU_LAT   = 1,
    parameter logic [DW-1:0] RESET_VAL = 4'b0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_instr_sequencer_if.slave bus,
    output logic                 busy,
    input  logic [AW-1:0]        dbg_addr,
    output logic [DW-1:0]        dbg_data,
    output logic [7:0]           instr_count
);
    state_t        r_state, w_next;
    logic [IW-1:0] r_instr;
    logic [DW-1:0] r_opa, r_opb, r_res_data;
    logic [AW-1:0] r_res_addr;
    logic [1:0]    r_cnt;
    logic [DW-1:0] w_alu, w_rs_data, w_rt_data, w_wdata;
    logic [AW-1:0] w_waddr;
    logic          w_we, w_idle, w_wb, w_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = (!bus.ld_en && bus.instr_valid) ? S_READ : S_IDLE;
            S_READ:  w_next = S_EXEC;
            S_EXEC:  w_next = (r_cnt == '0) ? S_WB : S_EXEC;
            default: w_next = S_IDLE;
        endcase
    end

    // A host load owns the write port in IDLE, so it also blocks acceptance.
    always_comb begin
        w_idle          = r_state == S_IDLE;
        w_wb            = r_state == S_WB;
        w_accept        = w_idle && !bus.ld_en && bus.instr_valid;
        bus.instr_ready = w_idle && !bus.ld_en;
        bus.res_valid   = w_wb;
        busy            = !w_idle;
        w_we            = w_wb || (w_idle && bus.ld_en);
        w_waddr         = w_wb ? r_res_addr : bus.ld_addr;
        w_wdata         = w_wb ? r_res_data : bus.ld_data;
    end

    // The result is captured on the last EXEC cycle so res_data/res_addr are
    // already valid while WB writes them back, and hold afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr    <= '0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_cnt      <= '0;
            r_res_data <= '0;
            r_res_addr <= '0;
        end else begin
            if (w_accept) r_instr <= bus.instr;
            if (r_state == S_READ) begin
                r_opa <= w_rs_data;
                r_opb <= w_rt_data;
                r_cnt <= 2'(ALU_LAT - 1);
            end
            if (r_state == S_EXEC) r_cnt <= r_cnt - 2'd1;
            if (r_state == S_EXEC && r_cnt == '0) begin
                r_res_data <= w_alu;
                r_res_addr <= r_instr[RD_LSB +: AW];
            end
        end
    end

    assign bus.res_data = r_res_data;
    assign bus.res_addr = r_res_addr;

    alu_seq_regfile #(.RESET_VAL(RESET_VAL)) u_rf (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_we),
        .i_waddr    (w_waddr),
        .i_wdata    (w_wdata),
        .i_rs_addr  (r_instr[RS_LSB +: AW]),
        .o_rs_data  (w_rs_data),
        .i_rt_addr  (r_instr[RT_LSB +: AW]),
        .o_rt_data  (w_rt_data),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

    Decode_And_Execute u_alu (
        .rs  (r_opa),
        .rt  (r_opb),
        .sel (r_instr[OP_LSB +: 3]),
        .rd  (w_alu)
    );

`ifdef INSTR_COUNT_EN
    logic [7:0] r_count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_count <= '0;
        else if (w_wb) r_count <= r_count + 8'd1;
    end
    assign instr_count = r_count;
`else
    assign instr_count = 8'd0;
`endif
endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb_alu_instr_sequencer: randomized + directed stimulus, scoreboard against a register-machine model.
module tb_alu_instr_sequencer;
    import alu_seq_pkg::*;
    localparam int LAT = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_addr = '0;
    logic [3:0] dbg_data;
    logic       busy;
    logic [7:0] instr_count;

    alu_instr_sequencer_if bus();

    alu_instr_sequencer #(.ALU_LAT(LAT), .RESET_VAL(4'b0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] addr;
        logic [3:0] data;
        int         due;
    } exp_t;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         retired = 0;
    logic [3:0] m [4];
    exp_t       q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [3:0] alu_ref(input logic [2:0] op, input int a, input int b);
        int r;
        case (op)
            3'd0: r = (a + b) % 16;
            3'd1: r = (a - b + 16) % 16;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = (a * 2 + a / 8) % 16;
            3'd5: r = b / 2 + (b >= 8 ? 8 : 0);
            3'd6: r = 14 + ((a == b) ? 1 : 0);
            default: r = 10 + ((a > b) ? 1 : 0);
        endcase
        return 4'(r);
    endfunction

    exp_t e;
    always @(negedge clk) begin
        if (bus.res_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_writeback: got res_addr=%0d res_data=%0d, expected none", bus.res_addr, bus.res_data);
            end else begin
                e = q.pop_front();
                check("res_data", int'(bus.res_data), int'(e.data));
                check("res_addr", int'(bus.res_addr), int'(e.addr));
                check("latency", cyc, e.due);
                retired++;
            end
        end
    end

    task automatic push_exp(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [1:0] rt);
        logic [3:0] r;
        r = alu_ref(op, int'(m[rs]), int'(m[rt]));
        q.push_back('{rd, r, cyc + 2 + LAT});
        m[rd] = r;
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [1:0] rt);
        int t = 0;
        @(negedge clk);
        bus.instr = {op, rd, rs, rt};
        bus.instr_valid = 1'b1;
        while (!bus.instr_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus.instr_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got instr_ready=0, expected 1 within 100 cycles");
            bus.instr_valid = 1'b0;
        end else begin
            push_exp(op, rd, rs, rt);
            @(posedge clk);
            #1 bus.instr_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while ((busy || q.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (busy || q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=%0d pending=%0d, expected 0 0", busy, q.size());
        end
    endtask

    task automatic load(input logic [1:0] a, input logic [3:0] d);
        @(negedge clk);
        bus.ld_en = 1'b1;
        bus.ld_addr = a;
        bus.ld_data = d;
        @(posedge clk);
        #1 bus.ld_en = 1'b0;
        m[a] = d;
    endtask

    task automatic check_reg(input logic [1:0] a, input string name);
        dbg_addr = a;
        #1 check(name, int'(dbg_data), int'(m[a]));
    endtask

    task automatic check_all_regs(input string name);
        for (int i = 0; i < 4; i++) check_reg(2'(i), name);
    endtask

    task automatic expect_count(input string name);
`ifdef INSTR_COUNT_EN
        check(name, int'(instr_count), retired % 256);
`else
        check(name, int'(instr_count), 0);
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        bus.ld_en = 1'b0;
        bus.ld_addr = '0;
        bus.ld_data = '0;
        for (int i = 0; i < 4; i++) m[i] = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_res_valid", int'(bus.res_valid), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", int'(bus.instr_ready), 1);
        check("rst_res_data", int'(bus.res_data), 0);
        check("rst_res_addr", int'(bus.res_addr), 0);
        check("rst_count", int'(instr_count), 0);
        check_all_regs("rst_regs");

        load(2'd0, 4'd5);
        load(2'd1, 4'd3);
        issue(OP_ADD, 2'd2, 2'd0, 2'd1);
        wait_idle();
        dbg_addr = 2'd2;
        #1 check("add_r2_const", int'(dbg_data), 8);
        issue(OP_SUB, 2'd3, 2'd1, 2'd0);
        issue(OP_GT, 2'd2, 2'd0, 2'd1);
        issue(OP_EQ, 2'd1, 2'd0, 2'd0);
        wait_idle();
        dbg_addr = 2'd3;
        #1 check("sub_wrap_const", int'(dbg_data), 14);
        dbg_addr = 2'd2;
        #1 check("gt_const", int'(dbg_data), 11);
        check_all_regs("arith_regs");

        load(2'd0, 4'b1001);
        load(2'd1, 4'b1000);
        issue(OP_ROL, 2'd2, 2'd0, 2'd0);
        issue(OP_ASR, 2'd3, 2'd0, 2'd1);
        wait_idle();
        dbg_addr = 2'd2;
        #1 check("rol_const", int'(dbg_data), 3);
        dbg_addr = 2'd3;
        #1 check("asr_const", int'(dbg_data), 12);
        load(2'd0, 4'd7);
        issue(OP_ADD, 2'd0, 2'd0, 2'd0);
        wait_idle();
        dbg_addr = 2'd0;
        #1 check("rd_eq_rs_const", int'(dbg_data), 14);

        // Simultaneous load and offer: load first, instruction sees the loaded value.
        @(negedge clk);
        bus.ld_en = 1'b1;
        bus.ld_addr = 2'd1;
        bus.ld_data = 4'd6;
        bus.instr = {OP_ADD, 2'd3, 2'd1, 2'd1};
        bus.instr_valid = 1'b1;
        #1 check("ready_during_load", int'(bus.instr_ready), 0);
        @(posedge clk);
        #1 bus.ld_en = 1'b0;
        m[1] = 4'd6;
        @(negedge clk);
        check("ready_after_load", int'(bus.instr_ready), 1);
        push_exp(OP_ADD, 2'd3, 2'd1, 2'd1);
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        wait_idle();
        dbg_addr = 2'd3;
        #1 check("load_then_instr_const", int'(dbg_data), 12);

        // Load during EXEC is dropped.
        issue(OP_OR, 2'd2, 2'd0, 2'd1);
        @(posedge clk);
        #1 begin
            bus.ld_en = 1'b1;
            bus.ld_addr = 2'd0;
            bus.ld_data = 4'd15;
        end
        @(posedge clk);
        #1 bus.ld_en = 1'b0;
        wait_idle();
        check_all_regs("load_in_exec_regs");
        expect_count("count_mid");

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(3) == 0) begin
                wait_idle();
                load(2'($urandom_range(3)), 4'($urandom_range(15)));
            end else begin
                issue(3'($urandom_range(7)), 2'($urandom_range(3)), 2'($urandom_range(3)), 2'($urandom_range(3)));
            end
        end
        wait_idle();
        check_all_regs("random_regs");

        // Reset during EXEC abandons the instruction.
        issue(OP_ADD, 2'd3, 2'd0, 2'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        for (int i = 0; i < 4; i++) m[i] = 4'd0;
        retired = 0;
        #1 check("midrst_res_valid", int'(bus.res_valid), 0);
        check("midrst_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready", int'(bus.instr_ready), 1);
        check("midrst_busy_after", int'(busy), 0);
        check_all_regs("midrst_regs");
        repeat (LAT + 4) @(negedge clk);
        expect_count("midrst_count");

        load(2'd1, 4'd1);
        for (int n = 0; n < 257; n++) issue(OP_ADD, 2'd0, 2'd0, 2'd1);
        wait_idle();
        check("retired_257", retired, 257);
        expect_count("count_wrap");
        check_all_regs("final_regs");
        check("drain", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
